// File: rtl/digit_entry.sv
// Four-digit BCD guess entry from switches and push-buttons, feeding checkInput.userInt.
// Define DIGIT_ENTRY_DEBOUNCE_EN to insert a counter debouncer on both buttons.

module digit_entry_btn #(
    parameter int DB_CYCLES = 500000,
    parameter int DB_CNT_W  = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DIGIT_ENTRY_DEBOUNCE_EN
    logic                r_db;
    logic [DB_CNT_W-1:0] r_cnt;

    // The debounced level only follows the synchroniser after DB_CYCLES
    // consecutive disagreeing samples; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == DB_CNT_W'(DB_CYCLES - 1)) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_db;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_press = w_level & ~r_prev;

endmodule

module digit_entry #(
    parameter int DB_CYCLES = 500000,
    parameter int DB_CNT_W  = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  sw,
    input  logic        btn_enter,
    input  logic        btn_del,
    output logic [15:0] userInt,
    output logic [2:0]  digit_cnt,
    output logic        entering,
    output logic        entry_done,
    output logic        invalid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] w_nextUser;
    logic [2:0]  w_nextCnt;
    logic        w_nextDone;
    logic        w_nextInvalid;
    logic        w_pressEnter;
    logic        w_pressDel;
    logic [1:0]  w_nib;
    logic [1:0]  w_delNib;

    digit_entry_btn #(
        .DB_CYCLES (DB_CYCLES),
        .DB_CNT_W  (DB_CNT_W)
    ) u_btnEnter (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_enter),
        .o_press (w_pressEnter)
    );

    digit_entry_btn #(
        .DB_CYCLES (DB_CYCLES),
        .DB_CNT_W  (DB_CNT_W)
    ) u_btnDel (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_del),
        .o_press (w_pressDel)
    );

    assign w_nib    = digit_cnt[1:0];
    assign w_delNib = digit_cnt[1:0] - 2'd1;

    // Start always wins over buttons; simultaneous enter+del is treated as no press.
    always_comb begin
        w_nextState   = r_state;
        w_nextUser    = userInt;
        w_nextCnt     = digit_cnt;
        w_nextDone    = 1'b0;
        w_nextInvalid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_ENTRY;
                    w_nextUser  = '0;
                    w_nextCnt   = '0;
                end
            end
            S_ENTRY: begin
                if (start) begin
                    w_nextUser = '0;
                    w_nextCnt  = '0;
                end else if (w_pressEnter && !w_pressDel) begin
                    if (sw <= 4'd9) begin
                        w_nextUser[{w_nib, 2'b00} +: 4] = sw;
                        w_nextCnt = digit_cnt + 3'd1;
                        if (digit_cnt == 3'd3) begin
                            w_nextDone  = 1'b1;
                            w_nextState = S_DONE;
                        end
                    end else begin
                        w_nextInvalid = 1'b1;
                    end
                end else if (w_pressDel && !w_pressEnter && digit_cnt != 3'd0) begin
                    w_nextUser[{w_delNib, 2'b00} +: 4] = 4'd0;
                    w_nextCnt = digit_cnt - 3'd1;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_nextState = S_ENTRY;
                    w_nextUser  = '0;
                    w_nextCnt   = '0;
                end
            end
            default: begin
                w_nextState = S_IDLE;
                w_nextUser  = '0;
                w_nextCnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            userInt    <= '0;
            digit_cnt  <= '0;
            entering   <= 1'b0;
            entry_done <= 1'b0;
            invalid    <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            userInt    <= w_nextUser;
            digit_cnt  <= w_nextCnt;
            entering   <= (w_nextState == S_ENTRY);
            entry_done <= w_nextDone;
            invalid    <= w_nextInvalid;
        end
    end

endmodule

// File: tb/tb_digit_entry.sv
// Scoreboard bench for digit_entry: a behavioural model pushes expected outputs per action,
// which are popped and compared once the button/start latency has elapsed.

module tb_digit_entry;

    localparam int DBC = 8;
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
    localparam int LAT = 2 + DBC;
`else
    localparam int LAT = 2;
`endif
    localparam int GAP = LAT + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  sw;
    logic        btn_enter;
    logic        btn_del;
    logic [15:0] userInt;
    logic [2:0]  digit_cnt;
    logic        entering;
    logic        entry_done;
    logic        invalid;

    digit_entry #(
        .DB_CYCLES (DBC),
        .DB_CNT_W  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sw         (sw),
        .btn_enter  (btn_enter),
        .btn_del    (btn_del),
        .userInt    (userInt),
        .digit_cnt  (digit_cnt),
        .entering   (entering),
        .entry_done (entry_done),
        .invalid    (invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] user;
        logic [2:0]  cnt;
        logic        ent;
        logic        done;
        logic        inv;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          mState = 0;
    logic [15:0] mUser = '0;
    int          mCnt = 0;
    int          mDoneCount = 0;
    int          doneSeen = 0;
    int          invSeen = 0;
    int          mInvCount = 0;

    always @(negedge clk) begin
        if (entry_done === 1'b1) doneSeen++;
        if (invalid === 1'b1) invSeen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpect(input string tag, input logic d, input logic i);
        exp_t e;
        e.tag  = tag;
        e.user = mUser;
        e.cnt  = 3'(mCnt);
        e.ent  = (mState == 1);
        e.done = d;
        e.inv  = i;
        q.push_back(e);
    endtask

    task automatic checkScoreboard();
        exp_t e;
        if (q.size() == 0) begin
            checkOutput("scoreboardEmpty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            checkOutput({e.tag, ".user"}, userInt, e.user);
            checkOutput({e.tag, ".cnt"}, digit_cnt, e.cnt);
            checkOutput({e.tag, ".entering"}, entering, e.ent);
            checkOutput({e.tag, ".done"}, entry_done, e.done);
            checkOutput({e.tag, ".invalid"}, invalid, e.inv);
        end
    endtask

    task automatic modelStart(input string tag);
        mState = 1;
        mUser  = '0;
        mCnt   = 0;
        pushExpect(tag, 1'b0, 1'b0);
    endtask

    task automatic modelButtons(input string tag, input logic en, input logic del, input logic [3:0] v);
        logic d;
        logic i;
        d = 1'b0;
        i = 1'b0;
        if (mState == 1 && en && !del) begin
            if (v <= 4'd9) begin
                mUser = mUser | (16'(v) << (4 * mCnt));
                mCnt++;
                if (mCnt == 4) begin
                    d = 1'b1;
                    mState = 2;
                    mDoneCount++;
                end
            end else begin
                i = 1'b1;
                mInvCount++;
            end
        end else if (mState == 1 && del && !en && mCnt > 0) begin
            mCnt--;
            mUser = mUser & ~(16'hF << (4 * mCnt));
        end
        pushExpect(tag, d, i);
    endtask

    task automatic applyStimulus(input string tag, input logic en, input logic del,
                                 input logic [3:0] v, input int hold);
        int prevCnt;
        @(negedge clk);
        sw        = v;
        btn_enter = en;
        btn_del   = del;
        prevCnt   = mCnt;
        modelButtons(tag, en, del, v);
        repeat (LAT) @(posedge clk);
        #1;
        checkOutput({tag, ".early"}, digit_cnt, 32'(prevCnt));
        @(posedge clk);
        #1;
        checkScoreboard();
        @(posedge clk);
        #1;
        checkOutput({tag, ".pulseLen"}, {entry_done, invalid}, 32'd0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        btn_enter = 1'b0;
        btn_del   = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
        checkOutput({tag, ".afterHold"}, digit_cnt, 32'(mCnt));
    endtask

    task automatic applyStart(input string tag);
        @(negedge clk);
        start = 1'b1;
        modelStart(tag);
        @(posedge clk);
        #1;
        checkScoreboard();
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        sw        = 4'd0;
        btn_enter = 1'b0;
        btn_del   = 1'b0;
        #1;
        checkOutput("reset.user", userInt, 32'h0);
        checkOutput("reset.cnt", digit_cnt, 32'd0);
        checkOutput("reset.flags", {entering, entry_done, invalid}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        applyStimulus("idleIgnore", 1'b1, 1'b0, 4'd5, 1);

        applyStart("start1");
        applyStimulus("d3", 1'b1, 1'b0, 4'd3, 1);
        applyStimulus("d7", 1'b1, 1'b0, 4'd7, 1);
        applyStimulus("d0", 1'b1, 1'b0, 4'd0, 1);
        applyStimulus("d9", 1'b1, 1'b0, 4'd9, 1);
        checkOutput("basic.user9073", userInt, 32'h9073);

        applyStimulus("doneEnter", 1'b1, 1'b0, 4'd5, 1);
        applyStimulus("doneDel", 1'b0, 1'b1, 4'd5, 1);
        applyStart("restart");

        applyStimulus("d5", 1'b1, 1'b0, 4'd5, 1);
        applyStimulus("d2", 1'b1, 1'b0, 4'd2, 1);
        applyStimulus("del1", 1'b0, 1'b1, 4'd2, 1);
        applyStimulus("del2", 1'b0, 1'b1, 4'd2, 1);
        applyStimulus("del3", 1'b0, 1'b1, 4'd2, 1);
        applyStimulus("d4", 1'b1, 1'b0, 4'd4, 1);
        checkOutput("delete.user0004", userInt, 32'h0004);

        applyStimulus("inv12", 1'b1, 1'b0, 4'd12, 1);
        applyStimulus("both", 1'b1, 1'b1, 4'd3, 1);
        applyStimulus("hold100", 1'b1, 1'b0, 4'd2, 100);

        // start lands on the same edge as an enter pulse: start wins, digit dropped
        @(negedge clk);
        sw        = 4'd6;
        btn_enter = 1'b1;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        modelStart("startVsEnter");
        @(posedge clk);
        #1;
        checkScoreboard();
        @(negedge clk);
        start     = 1'b0;
        btn_enter = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
        checkOutput("startVsEnter.after", digit_cnt, 32'd0);

`ifdef DIGIT_ENTRY_DEBOUNCE_EN
        @(negedge clk);
        sw        = 4'd1;
        btn_enter = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        btn_enter = 1'b0;
        repeat (3 * DBC) @(posedge clk);
        #1;
        checkOutput("glitch.cnt", digit_cnt, 32'(mCnt));
`endif

        applyStimulus("r1", 1'b1, 1'b0, 4'd1, 1);
        applyStimulus("r2", 1'b1, 1'b0, 4'd8, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midReset.user", userInt, 32'h0);
        checkOutput("midReset.cnt", digit_cnt, 32'd0);
        checkOutput("midReset.flags", {entering, entry_done, invalid}, 32'd0);
        mState = 0;
        mUser  = '0;
        mCnt   = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        applyStimulus("postResetIdle", 1'b1, 1'b0, 4'd4, 1);

        applyStart("start3");
        applyStimulus("f1", 1'b1, 1'b0, 4'd1, 1);
        applyStimulus("f2", 1'b1, 1'b0, 4'd2, 1);
        applyStimulus("f3", 1'b1, 1'b0, 4'd3, 1);
        applyStimulus("f4", 1'b1, 1'b0, 4'd4, 1);

        checkOutput("doneCount", doneSeen, mDoneCount);
        checkOutput("invalidCount", invSeen, mInvCount);
        checkOutput("scoreboardDrained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
